// File: rtl/axi_stream_output.sv
// SRAM-to-AXI4-Stream read-out engine.
// Reads a block from a selected SRAM and emits it as one packet.
module axi_stream_output #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_aresetn,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   length_i,
  input  logic [SEL_WIDTH-1:0]    sram_sel_i,
  output logic                    read_enable_o,
  output logic [ADDR_WIDTH-1:0]   read_address_o,
  output logic [SEL_WIDTH-1:0]    read_sram_sel_o,
  input  logic [DATA_WIDTH-1:0]   read_data_i,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, len_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, tx_cnt_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  inflight_q;
  logic [1:0]            count_q;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic                  start_ok, pop, push, rd_en;
  logic [2:0]            credit;

  assign start_ok = (state_q == IDLE) && start_i;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign push     = inflight_q;
  // Slots that will be occupied next cycle, before any new read.
  assign credit   = {1'b0, count_q} + {2'b0, inflight_q}
                  - {2'b0, pop};
  assign rd_en    = (state_q == STREAM) && (rd_cnt_q < len_q)
                  && (credit < 3'd2);

  assign read_enable_o   = rd_en;
  assign read_address_o  = base_q + rd_cnt_q;
  assign read_sram_sel_o = sel_q;
  assign m_axis_tvalid   = (count_q != 2'd0);
  assign m_axis_tdata    = head_q;
  assign m_axis_tstrb    = '1;
  assign m_axis_tlast    = m_axis_tvalid
                         && (tx_cnt_q == len_q - ONE);
  assign busy_o          = (state_q == STREAM);
  assign done_o          = (state_q == DONE);

  // State register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (length_i == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (pop && m_axis_tlast) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch and read/transmit counters.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      base_q     <= '0;
      len_q      <= '0;
      sel_q      <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (start_ok) begin
        base_q   <= base_addr_i;
        len_q    <= length_i;
        sel_q    <= sram_sel_i;
        rd_cnt_q <= '0;
        tx_cnt_q <= '0;
      end else begin
        if (rd_en) rd_cnt_q <= rd_cnt_q + ONE;
        if (pop)   tx_cnt_q <= tx_cnt_q + ONE;
      end
    end
  end

  // Two-entry output FIFO; head is the registered stream data.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) head_q <= read_data_i;
        end
        2'd1: begin
          if (push && pop) head_q <= read_data_i;
          else if (push)   tail_q <= read_data_i;
        end
        default: begin
          if (pop) head_q <= tail_q;
          if (push) tail_q <= read_data_i;
        end
      endcase
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_axi_stream_output.sv
// Randomized bench for axi_stream_output.
// Packet contents come from a behavioural SRAM and queue model.
module tb_axi_stream_output;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] len = '0;
  logic [SW-1:0] sel = '0;
  logic          re;
  logic [AW-1:0] addr;
  logic [SW-1:0] rsel;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] tdata;
  logic [0:0]    tstrb;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          busy;
  logic          done;

  axi_stream_output #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SEL_WIDTH (SW)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .start_i        (start),
    .base_addr_i    (base),
    .length_i       (len),
    .sram_sel_i     (sel),
    .read_enable_o  (re),
    .read_address_o (addr),
    .read_sram_sel_o(rsel),
    .read_data_i    (rdata),
    .m_axis_tdata   (tdata),
    .m_axis_tstrb   (tstrb),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_d [$];
  bit            exp_l [$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int m_base = 0;
  int m_len = 0;
  int rd_idx = 0;
  int issued = 0;
  int popped = 0;
  int nbeat = 0;
  int first_cyc = 0;
  int done_cyc = 0;
  bit done_seen = 0;
  bit hold_p = 0;
  logic [DW-1:0] hd;
  logic hl;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Behavioural SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stream monitor and scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_p = 0;
    end else begin
      chk("tstrb", 32'(tstrb), 1);
      if (hold_p) begin
        chk("hold_valid", 32'(tvalid), 1);
        chk("hold_data", 32'(tdata), 32'(hd));
        chk("hold_last", 32'(tlast), 32'(hl));
      end
      hold_p = tvalid && !tready;
      hd = tdata;
      hl = tlast;
      chk("outstanding", 32'((issued - popped) <= 2), 1);
      if (re) begin
        chk("rd_addr", 32'(addr), (m_base + rd_idx) % DEPTH);
        chk("rd_over", 32'(rd_idx < m_len), 1);
        rd_idx++;
        issued++;
      end
      if (tvalid && tready) begin
        if (exp_d.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("tdata", 32'(tdata), 32'(exp_d.pop_front()));
          chk("tlast", 32'(tlast), 32'(exp_l.pop_front()));
        end
        if (nbeat == 0) first_cyc = cyc;
        nbeat++;
        popped++;
      end
      if (done) begin
        chk("done_early", exp_d.size(), 0);
        done_seen = 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic do_start(input int b, input int l, input int s);
    @(posedge clk);
    #1;
    base = AW'(b);
    len = AW'(l);
    sel = SW'(s);
    start = 1'b1;
    m_base = b;
    m_len = l;
    rd_idx = 0;
    issued = 0;
    popped = 0;
    nbeat = 0;
    done_seen = 0;
    exp_d.delete();
    exp_l.delete();
    for (int i = 0; i < l; i++) begin
      exp_d.push_back(mem[(b + i) % DEPTH]);
      exp_l.push_back(i == l - 1);
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    chk("sel", 32'(rsel), 32'(s));
    chk("busy", 32'(busy), 32'(l != 0));
  endtask

  // mode 0: ready high, 1: random ready, 2: stall final beat 5 cycles
  task automatic run(input int mode, input bit inj);
    int stall;
    stall = 0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      case (mode)
        0: tready = 1'b1;
        1: tready = 1'($urandom_range(0, 1));
        default: begin
          tready = !(tlast && stall < 5);
          if (!tready) stall++;
        end
      endcase
      if (inj && i == 3) begin
        start = 1'b1;
        base = AW'($urandom);
        len = AW'($urandom_range(1, 20));
        sel = ~sel;
      end
      if (i == 4) start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_seen), 1);
    chk("beats", nbeat, m_len);
    chk("model_empty", exp_d.size(), 0);
    chk("busy_after", 32'(busy), 0);
    if (mode == 2) chk("stalls", stall, 5);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    #3;
    chk("rst_valid", 32'(tvalid), 0);
    chk("rst_re", 32'(re), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last", 32'(tlast), 0);
    chk("rst_sel", 32'(rsel), 0);
    #19;
    rst_n = 1'b1;

    // Basic packet with exact cycle timing.
    mem[10] = 8'sd5;
    mem[11] = -8'sd3;
    mem[12] = 8'sd127;
    mem[13] = -8'sd128;
    tready = 1'b1;
    do_start(10, 4, 2);
    run(0, 0);
    chk("first_beat_cyc", first_cyc, t0 + 2);
    chk("done_cyc", done_cyc, t0 + 6);
    chk("sel_basic", 32'(rsel), 2);

    // Back-pressure.
    do_start(300, 8, 4);
    run(1, 0);

    // Zero length.
    do_start(50, 0, 1);
    run(0, 0);
    chk("zero_done_cyc", done_cyc, t0);
    chk("zero_reads", issued, 0);

    // Address wrap with an ignored mid-packet start.
    do_start(8190, 4, 3);
    run(0, 1);
    chk("sel_hold", 32'(rsel), 3);

    // Stall on the final beat.
    do_start(1000, 5, 6);
    run(2, 0);

    // Reset in the middle of a packet.
    tready = 1'b1;
    do_start(100, 6, 5);
    for (int i = 0; i < 50 && nbeat < 2; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_beats", 32'(nbeat >= 2), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(tvalid), 0);
    chk("ar_last", 32'(tlast), 0);
    chk("ar_re", 32'(re), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_data", 32'(tdata), 0);
    chk("ar_addr", 32'(addr), 0);
    chk("ar_sel", 32'(rsel), 0);
    exp_d.delete();
    exp_l.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(200, 3, 1);
    run(0, 0);

    // Random packets.
    for (int k = 0; k < 6; k++) begin
      do_start($urandom_range(0, DEPTH - 1),
               $urandom_range(1, 12),
               $urandom_range(0, 7));
      run($urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
